// File: rtl/row_readout_pkg.sv
// Shared types and default sizing for the row readout collector and its buffer.
package row_readout_pkg;

    localparam int DEF_LENGTH     = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic {
        UNSYNC = 1'b0,
        RUN    = 1'b1
    } state_e;

endpackage

// File: rtl/readout_fifo.sv
// First-word-fall-through buffer: the head entry is visible in the cycle after it is written.
module readout_fifo
    import row_readout_pkg::*;
#(
    parameter  int WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // A full buffer still takes a write when the head leaves in the same cycle.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/row_readout_collector.sv
// Collects one-hot-addressed row samples in scan order, checks sequencing and
// buffers {row index, sample} pairs for a ready/valid consumer.
module row_readout_collector
    import row_readout_pkg::*;
#(
    parameter  int LENGTH     = DEF_LENGTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int IW         = $clog2(LENGTH),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample,
    input  logic [LENGTH-1:0]     sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_index,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done,
    output logic                  err_onehot,
    output logic                  err_sequence,
    output logic                  overflow
);

    state_e                     state_q, state_d;
    logic [IW-1:0]              exp_q, exp_d;
    logic                       frame_done_q, frame_done_d;
    logic                       err_onehot_q, err_onehot_d;
    logic                       err_sequence_q, err_sequence_d;
    logic                       overflow_q, overflow_d;

    logic [IW-1:0]              sel_idx;
    logic                       onehot_ok;
    logic                       accept, oh_evt, seq_evt, ovf_evt;
    logic                       fifo_full, fifo_empty, pop;
    logic [CW-1:0]              fifo_count;
    logic [IW+DATA_WIDTH-1:0]   fifo_head;

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (sel[k]) begin
                sel_idx = IW'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign onehot_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        accept  = 1'b0;
        oh_evt  = 1'b0;
        seq_evt = 1'b0;
        if (sample) begin
            if (!onehot_ok) begin
                oh_evt = 1'b1;
            end else begin
                case (state_q)
                    UNSYNC: begin
                        if (sel_idx == '0) begin
                            accept  = 1'b1;
                            exp_d   = IW'(1);
                            state_d = RUN;
                        end
                    end
                    RUN: begin
                        if (sel_idx == exp_q) begin
                            accept = 1'b1;
                            exp_d  = (exp_q == IW'(LENGTH - 1)) ? '0 : exp_q + 1'b1;
                        end else begin
                            seq_evt = 1'b1;
                            state_d = UNSYNC;
                        end
                    end
                    default: state_d = UNSYNC;
                endcase
            end
        end
    end

    assign pop     = out_ready && !fifo_empty;
    assign ovf_evt = accept && fifo_full && !pop;

    // A frame completes on the last row even if its sample was lost to overflow.
    assign frame_done_d   = accept && (state_q == RUN) && (sel_idx == IW'(LENGTH - 1));
    assign err_onehot_d   = (err_onehot_q   && !clear_err) || oh_evt;
    assign err_sequence_d = (err_sequence_q && !clear_err) || seq_evt;
    assign overflow_d     = (overflow_q     && !clear_err) || ovf_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= UNSYNC;
            exp_q          <= '0;
            frame_done_q   <= 1'b0;
            err_onehot_q   <= 1'b0;
            err_sequence_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            frame_done_q   <= frame_done_d;
            err_onehot_q   <= err_onehot_d;
            err_sequence_q <= err_sequence_d;
            overflow_q     <= overflow_d;
        end
    end

    readout_fifo #(
        .WIDTH (IW + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .data_i  ({sel_idx, data_in}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    assign out_valid    = (fifo_count != '0);
    assign out_index    = fifo_head[IW+DATA_WIDTH-1:DATA_WIDTH];
    assign out_data     = fifo_head[DATA_WIDTH-1:0];
    assign frame_done   = frame_done_q;
    assign err_onehot   = err_onehot_q;
    assign err_sequence = err_sequence_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_row_readout_collector.sv
// Directed bench for row_readout_collector: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_row_readout_collector;

    localparam int L  = 4;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample = 1'b0;
    logic [L-1:0]  sel = '0;
    logic [DW-1:0] data_in = '0;
    logic          clear_err = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [IW-1:0] out_index;
    logic [DW-1:0] out_data;
    logic          frame_done;
    logic          err_onehot;
    logic          err_sequence;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    row_readout_collector #(
        .LENGTH     (L),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sel          (sel),
        .data_in      (data_in),
        .clear_err    (clear_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_data     (out_data),
        .frame_done   (frame_done),
        .err_onehot   (err_onehot),
        .err_sequence (err_sequence),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: rows must arrive 0,1,..,L-1 after syncing on row 0.
    int  m_idx[$];
    int  m_dat[$];
    bit  m_sync = 0;
    int  m_exp = 0;
    bit  m_oh = 0, m_seq = 0, m_ov = 0, m_fd = 0;

    always @(posedge clk or posedge reset) begin
        bit pop, acc, e_oh, e_seq, e_ov, fd;
        int row;
        if (reset) begin
            m_idx.delete();
            m_dat.delete();
            m_sync = 0;
            m_exp  = 0;
            m_oh   = 0;
            m_seq  = 0;
            m_ov   = 0;
            m_fd   = 0;
        end else begin
            pop = (m_idx.size() > 0) && out_ready;
            acc = 0; e_oh = 0; e_seq = 0; e_ov = 0; fd = 0; row = 0;
            if (sample) begin
                if ($countones(sel) != 1) begin
                    e_oh = 1;
                end else begin
                    for (int k = 0; k < L; k++) if (sel[k]) row = k;
                    if (!m_sync) begin
                        if (row == 0) begin
                            acc = 1; m_sync = 1; m_exp = 1;
                        end
                    end else if (row == m_exp) begin
                        acc = 1;
                        fd = (row == L - 1);
                        m_exp = (m_exp + 1) % L;
                    end else begin
                        e_seq = 1; m_sync = 0;
                    end
                end
            end
            if (pop) begin
                void'(m_idx.pop_front());
                void'(m_dat.pop_front());
            end
            if (acc) begin
                if (m_idx.size() < FD) begin
                    m_idx.push_back(row);
                    m_dat.push_back(int'(data_in));
                end else begin
                    e_ov = 1;
                end
            end
            m_fd  = fd;
            m_oh  = (m_oh  && !clear_err) || e_oh;
            m_seq = (m_seq && !clear_err) || e_seq;
            m_ov  = (m_ov  && !clear_err) || e_ov;
        end
    end

    bit chk_en = 0;
    int log_idx[$];
    int log_dat[$];
    int fd_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid",    out_valid,    m_idx.size() > 0);
            check("out_index",    out_index,    (m_idx.size() > 0) ? m_idx[0] : 0);
            check("out_data",     out_data,     (m_dat.size() > 0) ? m_dat[0] : 0);
            check("frame_done",   frame_done,   m_fd);
            check("err_onehot",   err_onehot,   m_oh);
            check("err_sequence", err_sequence, m_seq);
            check("overflow",     overflow,     m_ov);
            if (out_valid && out_ready) begin
                log_idx.push_back(int'(out_index));
                log_dat.push_back(int'(out_data));
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic drive(input bit s, input logic [L-1:0] sl, input int d, input bit rdy, input bit clr);
        sample    = s;
        sel       = sl;
        data_in   = d[DW-1:0];
        out_ready = rdy;
        clear_err = clr;
        @(posedge clk);
        #1;
        $display("cycle: sample=%0b sel=%b data=%0d ready=%0b clr=%0b -> valid=%0b idx=%0d out=%0d fd=%0b oh=%0b seq=%0b ov=%0b",
                 s, sl, d, rdy, clr, out_valid, out_index, out_data, frame_done, err_onehot, err_sequence, overflow);
    endtask

    task automatic check_log(input string name, input int n, input int ei[8], input int ed[8]);
        check({name, "_len"}, log_idx.size(), n);
        for (int k = 0; k < n && k < log_idx.size(); k++) begin
            check({name, "_idx"}, log_idx[k], ei[k]);
            check({name, "_dat"}, log_dat[k], ed[k]);
        end
    endtask

    initial begin
        int ei[8];
        int ed[8];
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {frame_done, err_onehot, err_sequence, overflow}, 0);
        reset  = 1'b0;
        chk_en = 1;

        // Clean frame with a ready consumer.
        log_idx.delete(); log_dat.delete(); fd_count = 0;
        drive(1, 4'b0001, 10, 1, 0);
        check("fwft_valid", out_valid, 1);
        check("fwft_data", out_data, 10);
        drive(1, 4'b0010, 11, 1, 0);
        drive(1, 4'b0100, 12, 1, 0);
        drive(1, 4'b1000, 13, 1, 0);
        check("frame_done_pulse", frame_done, 1);
        repeat (3) drive(0, '0, 0, 1, 0);
        ei = '{0, 1, 2, 3, 0, 0, 0, 0};
        ed = '{10, 11, 12, 13, 0, 0, 0, 0};
        check_log("frame", 4, ei, ed);
        check("frame_done_count", fd_count, 1);

        // Invalid select vectors and clear priority.
        drive(1, 4'b0110, 55, 1, 0);
        check("onehot_set", err_onehot, 1);
        check("onehot_nopush", out_valid, 0);
        drive(0, '0, 0, 1, 1);
        check("onehot_clear", err_onehot, 0);
        drive(1, 4'b0000, 56, 1, 1);
        check("onehot_err_wins", err_onehot, 1);
        drive(0, '0, 0, 1, 1);

        // Sequence break and resync on row 0.
        log_idx.delete(); log_dat.delete();
        drive(1, 4'b0001, 20, 1, 0);
        drive(1, 4'b0010, 21, 1, 0);
        drive(1, 4'b1000, 22, 1, 0);
        check("seq_err_set", err_sequence, 1);
        drive(1, 4'b0100, 23, 1, 0);
        drive(1, 4'b0001, 30, 1, 0);
        drive(1, 4'b0010, 31, 1, 0);
        repeat (2) drive(0, '0, 0, 1, 0);
        ei = '{0, 1, 0, 1, 0, 0, 0, 0};
        ed = '{20, 21, 30, 31, 0, 0, 0, 0};
        check_log("resync", 4, ei, ed);
        drive(0, '0, 0, 1, 1);
        check("seq_err_clear", err_sequence, 0);

        // Overflow with a stalled consumer, then push+pop on a full buffer.
        log_idx.delete(); log_dat.delete();
        drive(1, 4'b0100, 40, 0, 0);
        drive(1, 4'b1000, 41, 0, 0);
        drive(1, 4'b0001, 42, 0, 0);
        drive(1, 4'b0010, 43, 0, 0);
        check("full_no_ovf", overflow, 0);
        drive(1, 4'b0100, 44, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_head_idx", out_index, 2);
        check("ovf_head_dat", out_data, 40);
        drive(1, 4'b1000, 45, 1, 0);
        check("pushpop_ovf_held", overflow, 1);
        check("pushpop_head", out_data, 41);
        repeat (6) drive(0, '0, 0, 1, 0);
        ei = '{2, 3, 0, 1, 3, 0, 0, 0};
        ed = '{40, 41, 42, 43, 45, 0, 0, 0};
        check_log("overflow", 5, ei, ed);
        drive(0, '0, 0, 1, 1);
        check("ovf_clear", overflow, 0);

        // Reset mid-frame with entries buffered.
        drive(1, 4'b0001, 50, 0, 0);
        drive(1, 4'b0010, 51, 0, 0);
        drive(1, 4'b0100, 52, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        log_idx.delete(); log_dat.delete();
        drive(1, 4'b0010, 61, 1, 0);
        check("post_rst_drop", out_valid, 0);
        drive(1, 4'b0001, 60, 1, 0);
        check("post_rst_accept", out_data, 60);
        repeat (3) drive(0, '0, 0, 1, 0);
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        ed = '{60, 0, 0, 0, 0, 0, 0, 0};
        check_log("post_rst", 1, ei, ed);
        check("post_rst_noseq", err_sequence, 0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_readout_collector.md
ROW_READOUT_COLLECTOR -- requirements
Module: row_readout_collector

Interface
REQ-001 Parameter LENGTH, default 4: number of rows (width of the one-hot select vector), range 2..32.
REQ-002 Parameter DATA_WIDTH, default 8: width of one row sample.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, range 2..16.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sample  input  1  strobe; sel and data_in are valid in this cycle.
REQ-007 sel  input  LENGTH  one-hot row-select vector from the row shifter.
REQ-008 data_in  input  DATA_WIDTH  row sample belonging to sel.
REQ-009 clear_err  input  1  synchronous clear of all sticky error flags.
REQ-010 out_valid  output  1  buffer head holds a sample.
REQ-011 out_ready  input  1  consumer accepts head when out_valid is high.
REQ-012 out_index  output  $clog2(LENGTH)  binary row index of head entry.
REQ-013 out_data  output  DATA_WIDTH  sample of head entry.
REQ-014 frame_done  output  1  one-cycle pulse after row LENGTH-1 is accepted into the buffer.
REQ-015 err_onehot, err_sequence, overflow  output  1 each  sticky error flags.

Function
REQ-016 On a sample cycle, sel SHALL be decoded to index i; sel with zero or more than one bit set SHALL set err_onehot and the sample SHALL be dropped without a state change.
REQ-017 FSM states UNSYNC and RUN; expected-index register exp, width $clog2(LENGTH).
REQ-018 UNSYNC: valid one-hot with i==0 SHALL be accepted, exp<=1, go to RUN; any other i SHALL be dropped silently.
REQ-019 RUN: i==exp SHALL be accepted, exp<=(exp+1) mod LENGTH (LENGTH-1 wraps to 0).
REQ-020 RUN: i!=exp SHALL set err_sequence, drop the sample, go to UNSYNC.
REQ-021 Accepted samples SHALL push {i, data_in} into the buffer; if the buffer is full and no pop occurs that cycle, the push SHALL be dropped, overflow set, and exp/state still advance as if accepted.
REQ-022 Push and pop in the same cycle on a full buffer SHALL both succeed; on an empty buffer the push SHALL succeed and no pop occurs.
REQ-023 Buffer SHALL be first-word-fall-through: a sample pushed at edge N SHALL show out_valid=1 from edge N onward (1-cycle latency).
REQ-024 Pop SHALL occur on an edge where out_valid && out_ready; out_index/out_data SHALL hold while out_valid && !out_ready.
REQ-025 out_index and out_data SHALL be 0 when out_valid is 0.
REQ-026 frame_done SHALL be high for exactly the cycle after an accept with i==LENGTH-1 in RUN, including when that push is dropped by overflow.
REQ-027 clear_err SHALL clear all three flags; an error event in the same cycle SHALL win (flag remains set).
REQ-028 sample low SHALL leave state, exp and flags unchanged.

Reset
REQ-029 Reset SHALL force state UNSYNC, exp=0, buffer empty, out_valid=0, out_index=0, out_data=0, frame_done=0, all flags=0.
REQ-030 Reset asserted mid-frame SHALL discard buffered entries; the first accepted sample after release SHALL be row 0.

Structure
REQ-031 A shared package row_readout_pkg SHALL hold the state enum (UNSYNC, RUN) and the default LENGTH/DATA_WIDTH/FIFO_DEPTH constants.
REQ-032 The buffer SHALL be a sub-module readout_fifo (synchronous, FWFT, full/empty, count), parameterised on width and depth.
REQ-033 The one-hot decoder and validity check SHALL be combinational inside row_readout_collector.

Verification
REQ-034 LENGTH=4: sel 0001,0010,0100,1000 with data 10,11,12,13, out_ready=1 -> outputs (0,10),(1,11),(2,12),(3,13) in order, one frame_done pulse.
REQ-035 sel=0110 with sample=1 -> err_onehot=1, no push; clear_err -> flag 0.
REQ-036 In RUN after rows 0,1, sel=1000 -> err_sequence=1, dropped; next 0100 dropped; 0001 accepted, RUN resumes.
REQ-037 out_ready=0, FIFO_DEPTH=4, five in-sequence samples -> first four buffered, overflow=1, fifth lost; then out_ready=1 with simultaneous push -> both succeed.
REQ-038 Reset asserted with 3 entries buffered -> out_valid=0 immediately; after release sel=0010 dropped, sel=0001 accepted.
